// File: rtl/cpu_isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_isa_pkg: opcode/ALU constants and stage-2 state encoding.              |
// | Optional MDWAIT state under STAGE2_MULTDIV_INTERLOCK_EN. Rev 1.0           |
// +----------------------------------------------------------------------------+
package cpu_isa_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
    , ST_MDWAIT = 2'd3
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stage2_hazard_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage2_hazard_cmp: picks the source registers an opcode reads and flags a  |
// | load-use conflict with the stage-3 load destination. Rev 1.0               |
// +----------------------------------------------------------------------------+
module stage2_hazard_cmp
  import cpu_isa_pkg::*;
#(
  parameter int OPW = 5,
  parameter int RW  = 5
) (
  input  logic [OPW-1:0] i_op,
  input  logic [RW-1:0]  i_rd,
  input  logic [RW-1:0]  i_rs,
  input  logic [RW-1:0]  i_rt,
  input  logic           i_ex_is_load,
  input  logic [RW-1:0]  i_ex_rd,
  output logic           o_hazard
);

  logic w_use_rs;
  logic w_use_rt;
  logic w_use_rd;

  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_use_rd = 1'b0;
    case (i_op)
      OP_R: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_ADDI, OP_LW: w_use_rs = 1'b1;
      // Stores and branches read rd as a data/compare operand.
      OP_SW, OP_BNE, OP_BLT: begin
        w_use_rs = 1'b1;
        w_use_rd = 1'b1;
      end
      OP_JR: w_use_rd = 1'b1;
      default: ;
    endcase
  end

  assign o_hazard = i_ex_is_load && (i_ex_rd != '0) &&
                    ((w_use_rs && (i_ex_rd == i_rs)) ||
                     (w_use_rt && (i_ex_rd == i_rt)) ||
                     (w_use_rd && (i_ex_rd == i_rd)));

endmodule
`default_nettype wire

// File: rtl/stage2_decode_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage2_decode_pipe: one-entry decode stage with load-use bubble and flush. |
// | STAGE2_MULTDIV_INTERLOCK_EN adds the mult/div wait handshake. Rev 1.0      |
// +----------------------------------------------------------------------------+
module stage2_decode_pipe
  import cpu_isa_pkg::*;
#(
  parameter int IW  = 32,
  parameter int OPW = 5,
  parameter int RW  = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] ir_in,
  input  logic          flush,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] ir_out,
  output logic          rd_is_src,
  output logic          is_jr,
  output logic [IW-1:0] bex_isn,
  output logic          hazard_stall
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
  ,
  input  logic          md_done,
  output logic          md_start
`endif
);

  state_t          r_state;
  logic [IW-1:0]   r_ir;
  logic            r_hazard_stall;
  logic [OPW-1:0]  w_op;
  logic            w_held;
  logic            w_full;
  logic            w_src_hit;
  logic            w_hazard;
  logic            w_md_hold;
  logic            w_accept;
  logic            w_capture;

  assign w_op   = r_ir[IW-1 -: OPW];
  assign w_held = (r_state != ST_EMPTY);
  assign w_full = (r_state == ST_FULL);

  stage2_hazard_cmp #(
    .OPW (OPW),
    .RW  (RW)
  ) u_hazard_cmp (
    .i_op         (w_op),
    .i_rd         (r_ir[IW-OPW-1 -: RW]),
    .i_rs         (r_ir[IW-OPW-RW-1 -: RW]),
    .i_rt         (r_ir[IW-OPW-2*RW-1 -: RW]),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .o_hazard     (w_src_hit)
  );

  assign w_hazard = w_full && w_src_hit;

`ifdef STAGE2_MULTDIV_INTERLOCK_EN
  logic r_md_ok;
  logic w_is_md;
  assign w_is_md   = (w_op == OP_R) && ((r_ir[6:2] == ALU_MUL) || (r_ir[6:2] == ALU_DIV));
  // r_md_ok marks a held mult/div whose unit has already finished.
  assign w_md_hold = w_full && w_is_md && !r_md_ok && !w_hazard;
  assign md_start  = w_md_hold && !flush;
`else
  assign w_md_hold = 1'b0;
`endif

  assign out_valid    = w_full && !w_hazard && !w_md_hold;
  assign w_accept     = out_valid && out_ready;
  assign in_ready     = (r_state == ST_EMPTY) || w_accept;
  assign w_capture    = in_valid && in_ready && !flush;
  assign hazard_stall = r_hazard_stall;
  assign ir_out       = r_ir;

  assign rd_is_src = w_held && ((w_op == OP_SW) || (w_op == OP_BNE) || (w_op == OP_BLT));
  assign is_jr     = w_held && (w_op == OP_JR);
  assign bex_isn   = w_held ? {{OPW{1'b0}}, r_ir[IW-OPW-1:0]} : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_EMPTY;
      r_ir           <= '0;
      r_hazard_stall <= 1'b0;
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
      r_md_ok        <= 1'b0;
`endif
    end else begin
      r_hazard_stall <= 1'b0;
      if (w_capture) begin
        r_ir <= ir_in;
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
        r_md_ok <= 1'b0;
`endif
      end
      if (flush) begin
        r_state <= ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_capture) r_state <= ST_FULL;
          end
          ST_FULL: begin
            if (w_hazard) begin
              r_state        <= ST_BUBBLE;
              r_hazard_stall <= 1'b1;
            end
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
            else if (w_md_hold) r_state <= ST_MDWAIT;
`endif
            else if (w_accept && !w_capture) r_state <= ST_EMPTY;
          end
          ST_BUBBLE: r_state <= ST_FULL;
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
          ST_MDWAIT: begin
            if (md_done) begin
              r_state <= ST_FULL;
              r_md_ok <= 1'b1;
            end
          end
`endif
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage2_decode_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stage2_decode_pipe: directed cases plus randomized run against a        |
// | behavioural model of the decode stage. Rev 1.0                             |
// +----------------------------------------------------------------------------+
module tb_stage2_decode_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir_in;
  logic        flush;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ir_out;
  logic        rd_is_src;
  logic        is_jr;
  logic [31:0] bex_isn;
  logic        hazard_stall;
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
  logic        md_done;
  logic        md_start;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the stage: whether an instruction is held, which one, and
  // whether this cycle is the post-hazard dead cycle.
  bit          m_have;
  bit          m_bubble;
  logic [31:0] m_ir;

  stage2_decode_pipe #(.IW(32), .OPW(5), .RW(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ir_in        (ir_in),
    .flush        (flush),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ir_out       (ir_out),
    .rd_is_src    (rd_is_src),
    .is_jr        (is_jr),
    .bex_isn      (bex_isn),
    .hazard_stall (hazard_stall)
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
    ,
    .md_done      (md_done),
    .md_start     (md_start)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_conflict(input logic [31:0] ir, input bit ld, input int exrd);
    int op, rd, rs, rt;
    op = int'(ir >> 27);
    rd = int'((ir >> 22) & 32'h1F);
    rs = int'((ir >> 17) & 32'h1F);
    rt = int'((ir >> 12) & 32'h1F);
    if (!ld || exrd == 0) return 1'b0;
    case (op)
      0:       return (exrd == rs) || (exrd == rt);
      5, 8:    return (exrd == rs);
      2, 6, 7: return (exrd == rs) || (exrd == rd);
      4:       return (exrd == rd);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    int ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    ir_in      = '0;
    flush      = 1'b0;
    ex_is_load = 1'b0;
    ex_rd      = '0;
    out_ready  = 1'b0;
`ifdef STAGE2_MULTDIV_INTERLOCK_EN
    md_done    = 1'b0;
`endif

    // Reset values
    #2;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_stall", hazard_stall, 1'b0);
    check32("rst_ir_out", ir_out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check1("rst_in_ready", in_ready, 1'b1);

    // Decode of sw, then backpressure
    in_valid = 1'b1;
    ir_in    = 32'h3A000004;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check1("sw_rd_is_src", rd_is_src, 1'b1);
    check1("sw_is_jr", is_jr, 1'b0);
    check32("sw_bex_isn", bex_isn, 32'h02000004);
    check1("sw_out_valid", out_valid, 1'b1);
    repeat (3) begin
      @(negedge clock);
      #1;
      check32("bp_ir_out", ir_out, 32'h3A000004);
      check1("bp_out_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
    end

    // Flush while full with a pending input
    flush    = 1'b1;
    in_valid = 1'b1;
    ir_in    = 32'h2C4A1234;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    check1("flush_rd_is_src", rd_is_src, 1'b0);
    check32("flush_bex_isn", bex_isn, 32'h0);
    check1("flush_nocap", ir_out == 32'h2C4A1234, 1'b0);

    // Flush while empty drops a would-be capture
    flush    = 1'b1;
    in_valid = 1'b1;
    ir_in    = 32'h20400000;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check1("flushe_out_valid", out_valid, 1'b0);
    check1("flushe_is_jr", is_jr, 1'b0);
    check1("flushe_in_ready", in_ready, 1'b1);

    // Load-use on rt of add $3,$1,$2
    in_valid = 1'b1;
    ir_in    = 32'h00C22000;
    @(negedge clock);
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd2;
    #1;
    check1("lu_det_out_valid", out_valid, 1'b0);
    check1("lu_det_in_ready", in_ready, 1'b0);
    check1("lu_det_stall", hazard_stall, 1'b0);
    @(negedge clock);
    ex_is_load = 1'b0;
    ex_rd      = 5'd0;
    #1;
    check1("lu_bub_stall", hazard_stall, 1'b1);
    check1("lu_bub_out_valid", out_valid, 1'b0);
    check1("lu_bub_in_ready", in_ready, 1'b0);
    @(negedge clock);
    #1;
    check1("lu_ret_stall", hazard_stall, 1'b0);
    check1("lu_ret_out_valid", out_valid, 1'b1);
    check32("lu_ret_ir_out", ir_out, 32'h00C22000);

    // Same case with ex_rd = 0: no bubble
    @(negedge clock);
    in_valid = 1'b1;
    ir_in    = 32'h00C22000;
    @(negedge clock);
    in_valid   = 1'b0;
    ex_is_load = 1'b1;
    ex_rd      = 5'd0;
    #1;
    check1("z0_out_valid", out_valid, 1'b1);
    check1("z0_stall", hazard_stall, 1'b0);
    @(negedge clock);
    ex_is_load = 1'b0;
    #1;
    check1("z0_done_out_valid", out_valid, 1'b0);
    check1("z0_done_stall", hazard_stall, 1'b0);
    check1("z0_done_in_ready", in_ready, 1'b1);

    // Asynchronous reset with an instruction held
    in_valid  = 1'b1;
    ir_in     = 32'h3A000004;
    out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check1("mr_pre_out_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("mr_out_valid", out_valid, 1'b0);
    check32("mr_ir_out", ir_out, 32'h0);
    check1("mr_rd_is_src", rd_is_src, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check1("mr_in_ready", in_ready, 1'b1);
    check1("mr_rel_out_valid", out_valid, 1'b0);

`ifdef STAGE2_MULTDIV_INTERLOCK_EN
    // mult: start pulse, wait for done, then emit once
    in_valid  = 1'b1;
    ir_in     = 32'h00C22018;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check1("md_start_pulse", md_start, 1'b1);
    check1("md_entry_out_valid", out_valid, 1'b0);
    check1("md_entry_in_ready", in_ready, 1'b0);
    repeat (2) begin
      @(negedge clock);
      #1;
      check1("md_wait_start", md_start, 1'b0);
      check1("md_wait_out_valid", out_valid, 1'b0);
      check1("md_wait_in_ready", in_ready, 1'b0);
    end
    md_done = 1'b1;
    @(negedge clock);
    md_done = 1'b0;
    #1;
    check1("md_done_out_valid", out_valid, 1'b1);
    check1("md_done_start", md_start, 1'b0);
    check32("md_done_ir_out", ir_out, 32'h00C22018);
    @(negedge clock);
    #1;
    check1("md_emitted_once", out_valid, 1'b0);
`endif

    // Randomized run against the model; the stage is empty here
    out_ready = 1'b0;
    m_have    = 1'b0;
    m_bubble  = 1'b0;
    m_ir      = '0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r_ins;
      bit          e_hz, e_ov, e_ir, e_src, e_jr;
      int          op;
      @(negedge clock);
      op    = ops[$urandom_range(0, 10)];
      r_ins = (32'(op) << 27) | (32'($urandom_range(0, 3)) << 22) |
              (32'($urandom_range(0, 3)) << 17) | (32'($urandom_range(0, 3)) << 12) |
              ($urandom & 32'h00000F83);
      ir_in      = r_ins;
      in_valid   = ($urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < 7);
      ex_is_load = ($urandom_range(0, 9) < 4);
      ex_rd      = 5'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 19) == 0);
      #1;
      e_hz  = m_have && !m_bubble && model_conflict(m_ir, ex_is_load, int'(ex_rd));
      e_ov  = m_have && !m_bubble && !e_hz;
      e_ir  = !m_have || (e_ov && out_ready);
      op    = int'(m_ir >> 27);
      e_src = m_have && (op == 7 || op == 2 || op == 6);
      e_jr  = m_have && (op == 4);
      check1("rnd_out_valid", out_valid, e_ov);
      check1("rnd_in_ready", in_ready, e_ir);
      check1("rnd_stall", hazard_stall, m_bubble);
      check1("rnd_rd_is_src", rd_is_src, e_src);
      check1("rnd_is_jr", is_jr, e_jr);
      check32("rnd_bex_isn", bex_isn, m_have ? (m_ir & 32'h07FFFFFF) : 32'h0);
      if (m_have) check32("rnd_ir_out", ir_out, m_ir);
      @(posedge clock);
      if (flush) begin
        m_have   = 1'b0;
        m_bubble = 1'b0;
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (e_hz) begin
        m_bubble = 1'b1;
      end else if (in_valid && e_ir) begin
        m_have = 1'b1;
        m_ir   = ir_in;
      end else if (e_ov && out_ready) begin
        m_have = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
